flash_playback_sequencer: RTL and testbench
===========================================

Name: flash_playback_sequencer

Overview:
- Sequences 32-bit word reads from the on-board flash memory master and streams 16-bit audio samples to the audio output path, one sample per sample-rate strobe.
- Driven by the keyboard control FSM outputs: direction, pause and restart.
- Sits between the keyboard controller, the sample-rate clock divider and the flash read port.

Parameters:
- ADDR_W, 23, flash word address width.
- START_ADDR, 23'h000000, first word of the audio clip.
- END_ADDR, 23'h07FFFF, last word of the audio clip (inclusive).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous reset, active-low (asserted when 0).
- direction  input  1  1 = forward (incrementing address), 0 = backward.
- pause  input  1  1 = hold playback.
- restart  input  1  level; request jump to start of clip for the current direction.
- sample_tick  input  1  one-cycle strobe at the audio sample rate.
- flash_mem_read  output  1  read request.
- flash_mem_address  output  ADDR_W  word address of the request.
- flash_mem_waitrequest  input  1  slave stall.
- flash_mem_readdata  input  32  returned word.
- flash_mem_readdatavalid  input  1  readdata valid, one cycle.
- audio_data  output  16  current sample (signed, passed through unchanged).
- audio_valid  output  1  one-cycle pulse when audio_data updates.
- busy  output  1  high while a flash read is outstanding.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, address=START_ADDR, flash_mem_read=0, audio_data=16'h0000, audio_valid=0, busy=0, restart_pending=0, word buffer=0.
- States: IDLE, REQ, WAIT_DATA, WAIT_TICK_A, WAIT_TICK_B, ADVANCE.
- IDLE:
  - Leaves when pause==0.
  - If restart_pending is set, load the restart address and clear restart_pending.
  - Then go to REQ.
- REQ:
  - flash_mem_read=1, busy=1, and flash_mem_address is held stable.
  - When waitrequest==0 at the edge, drop read and go to WAIT_DATA.
  - Read is never dropped while waitrequest==1.
- WAIT_DATA:
  - busy=1.
  - On readdatavalid, capture readdata into the word buffer, clear busy and go to WAIT_TICK_A.
  - Data arriving outside WAIT_DATA is ignored.
- Half order:
  - Forward: first sample is readdata[15:0], second is [31:16].
  - Backward: first is [31:16], second is [15:0].
  - The half order is latched from direction at capture.
- WAIT_TICK_A:
  - When sample_tick==1 and pause==0, audio_data <= first half and audio_valid=1 for exactly one cycle (visible the cycle after the tick). Go to WAIT_TICK_B.
- WAIT_TICK_B:
  - Same handshake, outputting the second half, then go to ADVANCE.
- ADVANCE (one cycle):
  - Forward: address+1; END_ADDR wraps to START_ADDR.
  - Backward: address-1; START_ADDR wraps to END_ADDR.
  - Then go to REQ.
  - direction is sampled here, so a direction change takes effect on the next word.
- Pause:
  - Ticks are ignored in WAIT_TICK_A/B. audio_data holds and audio_valid stays 0.
  - An in-flight read (REQ/WAIT_DATA) completes normally.
  - On resume, output continues from the buffered half with no sample lost.
- Restart:
  - Any cycle with restart==1 sets restart_pending.
  - It is applied at the next entry to WAIT_TICK_A, WAIT_TICK_B, ADVANCE or IDLE: address <= START_ADDR if direction==1, else END_ADDR. The buffer is discarded, restart_pending is cleared and the FSM goes to REQ.
  - No sample is emitted between restart application and the new word.
  - A read already in flight completes before restart is applied (no abandoned transaction).
- Simultaneous events:
  - restart has priority over sample_tick in the same cycle.
  - pause and restart together: the address reloads, the FSM goes to REQ, fetches, then holds in WAIT_TICK_A.
- Reset mid-transaction: the FSM returns to IDLE and flash_mem_read drops on the next edge; a late readdatavalid is ignored.
- Address arithmetic is ADDR_W bits wide; the wrap comparison uses equality only.

Optional Feature:
- Macro PLAYBACK_ONESHOT_EN.
- When defined:
  - Reaching the boundary in ADVANCE (END_ADDR forward, START_ADDR backward) goes to IDLE with the address parked at the boundary. There is no wrap.
  - Add output port done (1 bit, reset 0), set on that transition and cleared by restart.
  - IDLE then requires restart before playing again.
- When undefined: wrap-around as above, and no done port exists.

Test Plan:
- Reset low 2 cycles, then high, pause=0, direction=1, readdata=32'hBBBBAAAA, waitrequest=0 → address 0 read. Two ticks give audio_data 16'hAAAA then 16'hBBBB, each with a one-cycle audio_valid. Next read at address 1.
- direction=0, address at START_ADDR, readdata=32'h22221111 → outputs 16'h2222 then 16'h1111, next read address END_ADDR (wrap).
- waitrequest held high 5 cycles during REQ → flash_mem_read and address stable all 5 cycles, single transaction, busy high throughout.
- pause=1 in WAIT_TICK_B for 10 ticks → no audio_valid, audio_data holds. pause=0 → next tick emits the buffered second half.
- restart pulse during WAIT_DATA, forward, address 0x100 → read completes; next request address START_ADDR, with no audio_valid between.
- PLAYBACK_ONESHOT_EN, END_ADDR=3, forward from 0 → 8 samples, done=1, flash_mem_read stays 0. restart → done=0, read at 0.

Source files
------------

// File: rtl/flash_playback_sequencer.sv
// Flash-to-audio playback sequencer: fetches 32-bit flash words and emits their two 16-bit halves on sample_tick.
// Build option PLAYBACK_ONESHOT_EN: park at the clip boundary and raise done instead of wrapping.
module flash_playback_sequencer #(
    parameter int unsigned       ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              direction,
    input  logic              pause,
    input  logic              restart,
    input  logic              sample_tick,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid,
    output logic [15:0]       audio_data,
    output logic              audio_valid,
`ifdef PLAYBACK_ONESHOT_EN
    output logic              done,
`endif
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        WAIT_TICK_A,
        WAIT_TICK_B,
        ADVANCE
    } state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W-1:0] restart_addr;
    logic [ADDR_W-1:0] step_addr;
    logic [31:0]       word_buf;
    logic              half_fwd;
    logic              restart_pending;
    logic              restart_req;
    logic              restart_apply;
    logic              tick_ok;
    logic              at_boundary;
    logic              oneshot_stop;
    logic              idle_hold;
    logic [15:0]       first_half;
    logic [15:0]       second_half;

    // A restart raised this cycle counts the same as one remembered from earlier.
    assign restart_req  = restart | restart_pending;
    assign tick_ok      = sample_tick & ~pause;
    assign at_boundary  = direction ? (address == END_ADDR) : (address == START_ADDR);
    assign restart_addr = direction ? START_ADDR : END_ADDR;
    assign first_half   = half_fwd ? word_buf[15:0]  : word_buf[31:16];
    assign second_half  = half_fwd ? word_buf[31:16] : word_buf[15:0];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        step_addr = address;
        if (at_boundary) begin
            step_addr = restart_addr;
        end else if (direction) begin
            step_addr = address + ADDR_W'(1);
        end else begin
            step_addr = address - ADDR_W'(1);
        end
    end

    // Restart only takes effect where no flash transaction is outstanding.
    always_comb begin
        restart_apply = 1'b0;
        unique case (state)
            IDLE:                              restart_apply = restart_req & ~pause;
            WAIT_TICK_A, WAIT_TICK_B, ADVANCE: restart_apply = restart_req;
            default:                           restart_apply = 1'b0;
        endcase
    end

`ifdef PLAYBACK_ONESHOT_EN
    logic done_q;

    assign oneshot_stop = at_boundary;
    assign idle_hold    = done_q & ~restart_req;
    assign done         = done_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            done_q <= 1'b0;
        end else if (restart_apply) begin
            done_q <= 1'b0;
        end else if (state == ADVANCE && at_boundary) begin
            done_q <= 1'b1;
        end
    end
`else
    assign oneshot_stop = 1'b0;
    assign idle_hold    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:        if (!pause && !idle_hold) next_state = REQ;
            REQ:         if (!flash_mem_waitrequest) next_state = WAIT_DATA;
            WAIT_DATA:   if (flash_mem_readdatavalid) next_state = WAIT_TICK_A;
            WAIT_TICK_A: begin
                if (restart_req)  next_state = REQ;
                else if (tick_ok) next_state = WAIT_TICK_B;
            end
            WAIT_TICK_B: begin
                if (restart_req)  next_state = REQ;
                else if (tick_ok) next_state = ADVANCE;
            end
            ADVANCE: begin
                if (restart_req)       next_state = REQ;
                else if (oneshot_stop) next_state = IDLE;
                else                   next_state = REQ;
            end
            default:     next_state = IDLE;
        endcase
    end

    always_comb begin
        flash_mem_read    = (state == REQ);
        busy              = (state == REQ) || (state == WAIT_DATA);
        flash_mem_address = address;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            address         <= START_ADDR;
            word_buf        <= '0;
            half_fwd        <= 1'b0;
            restart_pending <= 1'b0;
            audio_data      <= 16'h0000;
            audio_valid     <= 1'b0;
        end else begin
            audio_valid     <= 1'b0;
            restart_pending <= restart_apply ? 1'b0 : (restart_pending | restart);
            unique case (state)
                IDLE: begin
                    if (restart_apply) begin
                        address  <= restart_addr;
                        word_buf <= '0;
                    end
                end
                WAIT_DATA: begin
                    if (flash_mem_readdatavalid) begin
                        word_buf <= flash_mem_readdata;
                        half_fwd <= direction;
                    end
                end
                WAIT_TICK_A: begin
                    if (restart_apply) begin
                        address  <= restart_addr;
                        word_buf <= '0;
                    end else if (tick_ok) begin
                        audio_data  <= first_half;
                        audio_valid <= 1'b1;
                    end
                end
                WAIT_TICK_B: begin
                    if (restart_apply) begin
                        address  <= restart_addr;
                        word_buf <= '0;
                    end else if (tick_ok) begin
                        audio_data  <= second_half;
                        audio_valid <= 1'b1;
                    end
                end
                ADVANCE: begin
                    if (restart_apply) begin
                        address  <= restart_addr;
                        word_buf <= '0;
                    end else if (!oneshot_stop) begin
                        address <= step_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_playback_sequencer.sv
// Scoreboard bench: stimulus queues expected samples and read addresses; a flash model and an audio monitor pop and compare.
// With PLAYBACK_ONESHOT_EN defined it runs the one-shot sequence on a 4-word clip instead of the wrap sequence.
module tb_flash_playback_sequencer;

`ifdef PLAYBACK_ONESHOT_EN
    localparam logic [22:0] END_A = 23'h000003;
`else
    localparam logic [22:0] END_A = 23'h000103;
`endif
    localparam logic [22:0] START_A = 23'h000000;
    localparam int          STALL_READ = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        direction = 1'b1;
    logic        pause = 1'b0;
    logic        restart = 1'b0;
    logic        sample_tick = 1'b0;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic        flash_mem_waitrequest = 1'b0;
    logic [31:0] flash_mem_readdata = 32'h0;
    logic        flash_mem_readdatavalid = 1'b0;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        busy;
`ifdef PLAYBACK_ONESHOT_EN
    logic        done;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_samples[$];
    logic [22:0] exp_addrs[$];
    logic [31:0] mem[0:259];
    int          accepts = 0;
    int          deliveries = 0;
    int          word_target = 0;
    int          stall_left = 0;
    bit          in_txn = 1'b0;
    logic [22:0] stall_addr = '0;
    int          lat_cnt = 0;
    logic [31:0] resp_word = '0;

    always #5 clock = ~clock;

    flash_playback_sequencer #(
        .ADDR_W    (23),
        .START_ADDR(START_A),
        .END_ADDR  (END_A)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .direction              (direction),
        .pause                  (pause),
        .restart                (restart),
        .sample_tick            (sample_tick),
        .flash_mem_read         (flash_mem_read),
        .flash_mem_address      (flash_mem_address),
        .flash_mem_waitrequest  (flash_mem_waitrequest),
        .flash_mem_readdata     (flash_mem_readdata),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .audio_data             (audio_data),
        .audio_valid            (audio_valid),
`ifdef PLAYBACK_ONESHOT_EN
        .done                   (done),
`endif
        .busy                   (busy)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Flash slave model: optional stall on one chosen read, data returned two cycles after acceptance.
    always @(negedge clock) begin
        flash_mem_readdatavalid = 1'b0;
        flash_mem_waitrequest   = 1'b0;
        if (!reset) begin
            lat_cnt = 0;
            in_txn  = 1'b0;
        end else begin
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    flash_mem_readdatavalid = 1'b1;
                    flash_mem_readdata      = resp_word;
                    deliveries++;
                end
            end
            if (flash_mem_read) begin
                if (!in_txn) begin
                    in_txn     = 1'b1;
                    stall_left = (accepts == STALL_READ) ? 5 : 0;
                    stall_addr = flash_mem_address;
                end
                if (stall_left > 0) begin
                    check("stall_addr_stable", 32'(flash_mem_address), 32'(stall_addr));
                    check("stall_busy", 32'(busy), 32'd1);
                    flash_mem_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    check("accept_addr_stable", 32'(flash_mem_address), 32'(stall_addr));
                    in_txn = 1'b0;
                    accepts++;
                    if (exp_addrs.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_read: address %h, no read expected", flash_mem_address);
                    end else begin
                        check("read_addr", 32'(flash_mem_address), 32'(exp_addrs.pop_front()));
                    end
                    resp_word = (flash_mem_address <= 23'd259) ? mem[int'(flash_mem_address)] : 32'hDEADBEEF;
                    lat_cnt   = 2;
                end
            end
        end
    end

    // Audio monitor: every audio_valid cycle must match the next queued sample.
    always @(negedge clock) begin
        if (reset && audio_valid) begin
            if (exp_samples.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample: audio_data %h, no sample expected", audio_data);
            end else begin
                check("audio_data", 32'(audio_data), 32'(exp_samples.pop_front()));
            end
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_word();
        int n = 0;
        word_target++;
        while (deliveries < word_target && n < 200) begin
            cycle();
            n++;
        end
        if (deliveries < word_target) begin
            checks++;
            failures++;
            $display("FAIL word_timeout: %0d words delivered, required %0d", deliveries, word_target);
        end
    endtask

    task automatic wait_accept(input int target);
        int n = 0;
        while (accepts < target && n < 200) begin
            cycle();
            n++;
        end
        if (accepts < target) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: %0d reads accepted, required %0d", accepts, target);
        end
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
    endtask

    task automatic emit(input logic [15:0] s);
        exp_samples.push_back(s);
        tick();
    endtask

    task automatic play_word(input logic [15:0] s0, input logic [15:0] s1, input logic [22:0] next_a);
        wait_word();
        exp_addrs.push_back(next_a);
        emit(s0);
        emit(s1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 260; a++) mem[a] = {16'hA000 + 16'(a), 16'h5000 + 16'(a)};
        mem[0] = 32'hBBBBAAAA;

        repeat (2) cycle();
        check("rst_read", 32'(flash_mem_read), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_audio_valid", 32'(audio_valid), 32'd0);
        check("rst_audio_data", 32'(audio_data), 32'h0000);
        check("rst_address", 32'(flash_mem_address), 32'(START_A));
`ifdef PLAYBACK_ONESHOT_EN
        check("rst_done", 32'(done), 32'd0);
`endif
        exp_addrs.push_back(23'h000000);
        reset = 1'b1;

`ifdef PLAYBACK_ONESHOT_EN
        play_word(16'hAAAA, 16'hBBBB, 23'h000001);
        play_word(16'h5001, 16'hA001, 23'h000002);
        play_word(16'h5002, 16'hA002, 23'h000003);
        wait_word();
        emit(16'h5003);
        emit(16'hA003);
        repeat (10) begin
            cycle();
            check("oneshot_read_low", 32'(flash_mem_read), 32'd0);
        end
        check("oneshot_done", 32'(done), 32'd1);
        check("oneshot_parked", 32'(flash_mem_address), 32'h000003);
        exp_addrs.push_back(23'h000000);
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        check("oneshot_done_cleared", 32'(done), 32'd0);
        wait_accept(5);
        repeat (5) cycle();
        check("total_reads", 32'(accepts), 32'd5);
`else
        // Forward word 0, then word 1 with direction flipped after capture.
        play_word(16'hAAAA, 16'hBBBB, 23'h000001);
        wait_word();
        direction = 1'b0;
        mem[0] = 32'h22221111;
        exp_addrs.push_back(23'h000000);
        emit(16'h5001);
        emit(16'hA001);

        // Backward at START wraps to END.
        play_word(16'h2222, 16'h1111, END_A);

        // END word (stalled read), paused for 10 ticks between halves.
        wait_word();
        exp_addrs.push_back(23'h000102);
        emit(16'hA103);
        pause = 1'b1;
        repeat (10) begin
            tick();
            cycle();
        end
        check("pause_hold_data", 32'(audio_data), 32'h0000A103);
        check("pause_valid_low", 32'(audio_valid), 32'd0);
        pause = 1'b0;
        emit(16'h5103);

        play_word(16'hA102, 16'h5102, 23'h000101);
        play_word(16'hA101, 16'h5101, 23'h000100);

        // Restart during WAIT_DATA of word 0x100; a tick alongside the pending restart is ignored.
        wait_accept(7);
        check("busy_wait_data", 32'(busy), 32'd1);
        direction = 1'b1;
        exp_addrs.push_back(START_A);
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        wait_word();
        tick();

        play_word(16'h1111, 16'h2222, 23'h000001);

        // Restart backward from WAIT_TICK_A jumps to END; forward from END wraps to START.
        wait_word();
        exp_addrs.push_back(END_A);
        direction = 1'b0;
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        direction = 1'b1;
        play_word(16'h5103, 16'hA103, START_A);
        wait_word();
        repeat (5) cycle();
        check("total_reads", 32'(accepts), 32'd11);
`endif
        check("samples_drained", 32'(exp_samples.size()), 32'd0);
        check("addrs_drained", 32'(exp_addrs.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
